// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file bank.
// Provides default geometry, the hardwired-zero address and address-width math.
package regfile_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 32;
    localparam int ZERO_ADDR = 0;

    // Address bits needed to name DEPTH registers (never less than 1).
    function automatic int addr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/dffe_vec.sv
// Vector enable register with asynchronous active-high clear.
// Ports: clk, clr (async clear), en (load enable), d (next value), q (state).
module dffe_vec
    import regfile_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_bank.sv
// Register file: 1 write port, 2 read ports, optional zero register,
// optional write-to-read bypass and a per-register busy scoreboard.
// Ports: clk, clr (async clear), we/waddr/wdata (write), raddr_a/raddr_b
// (reads) -> rdata_a/rdata_b, bset/baddr (mark busy) -> busy_a/busy_b.
module regfile_bank
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = addr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             bset,
    input  logic [AW-1:0]    baddr,
    output logic             busy_a,
    output logic             busy_b
);

    logic [WIDTH-1:0] words [DEPTH];
    logic [DEPTH-1:0] wen;
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             wr_ok;
    logic             set_ok;

    // An address names real storage: in range and not the hardwired zero.
    function automatic logic legal(input logic [AW-1:0] a);
        logic ok;
        ok = int'(a) < DEPTH;
        if (ZERO_REG != 0 && a == AW'(ZERO_ADDR)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // clr gates the write so a clearing bank never forwards stale wdata.
    assign wr_ok  = we && !clr && legal(waddr);
    assign set_ok = bset && legal(baddr);

    always_comb begin
        wen = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wen[i] = wr_ok && (waddr == AW'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        dffe_vec #(.WIDTH(WIDTH)) u_word (
            .clk (clk),
            .clr (clr),
            .en  (wen[g]),
            .d   (wdata),
            .q   (words[g])
        );
    end

    // Release first, then set: a new producer issuing in the same
    // cycle as the old result retiring keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && waddr == AW'(i)) begin
                busy_d[i] = 1'b0;
            end
            if (set_ok && baddr == AW'(i)) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    dffe_vec #(.WIDTH(DEPTH)) u_busy (
        .clk (clk),
        .clr (clr),
        .en  (1'b1),
        .d   (busy_d),
        .q   (busy_q)
    );

    function automatic logic [WIDTH-1:0] read_word(
        input logic [AW-1:0] a
    );
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a == AW'(i)) begin
                r = words[i];
            end
        end
        if (!legal(a)) begin
            r = '0;
        end
        if (BYPASS != 0 && wr_ok && waddr == a) begin
            r = wdata;
        end
        return r;
    endfunction

    // Busy is never bypassed; consumers rely on the data bypass instead.
    function automatic logic read_busy(input logic [AW-1:0] a);
        logic b;
        b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (a == AW'(i)) begin
                b = busy_q[i];
            end
        end
        return b && legal(a);
    endfunction

    always_comb begin
        rdata_a = read_word(raddr_a);
        rdata_b = read_word(raddr_b);
        busy_a  = read_busy(raddr_a);
        busy_b  = read_busy(raddr_b);
    end

endmodule
